cpa8_seq_add: RTL
=================

# cpa8_seq_add

Multi-precision add/subtract sequencer that reuses one 8-bit ripple-carry adder (`cpa8`) over several cycles to produce a WORDS×8-bit result. It latches two wide operands on a start handshake, feeds one byte slice per cycle through the shared `cpa8`, and chains the carry through a register. It then presents the wide sum with a valid/ready output handshake. It sits between a requesting datapath and the existing `cpa8` datapath, trading latency for adder area.

## Interface
- `WORDS`, default 4: number of 8-bit slices; operand width W = 8*WORDS; legal range 2..16.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; accepted only when `ready`=1.
- `sub`  in  1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a`  in  W: operand A; sampled with `start`.
- `b`  in  W: operand B; sampled with `start`.
- `ready`  out  1: block idle, will accept `start`.
- `out_valid`  out  1: `sum`/`cout` hold a completed result.
- `out_ready`  in  1: consumer accepts the result.
- `sum`  out  W: result, modulo 2^W.
- `cout`  out  1: carry out of MSB (for sub: 1 = no borrow).
- `ovf`  out  1: signed overflow; present only with `CPA8_SEQ_OVF_EN`.

## Operation
- Registers: A, B, result, carry register `c`, slice index `k` (`$clog2(WORDS)` bits), and state.
- FSM states and transitions:
  - IDLE: `ready`=1. On `start`, latch `a`, `b` (B stored as ~b when `sub`=1) and `sub`. Set `c`=`sub`, `k`=0, then go to RUN.
  - RUN: drive `cpa8` with num1=A[8k+7:8k], num2=B[8k+7:8k], cin=`c`. Write `out` to result[8k+7:8k], load `c`←`cout` of `cpa8`, and increment `k`. When `k`=WORDS−1, the cycle's carry becomes `cout` and the state goes to DONE.
  - DONE: `out_valid`=1. `sum`, `cout` and `ovf` are held stable. On `out_ready`=1, return to IDLE.
- `start` outside IDLE is ignored. There is no queueing and no error flag.
- Operands are captured, so `a`, `b` and `sub` may change freely after acceptance.
- Subtraction is two's complement: A + ~B + 1, with cin of slice 0 = 1.
- Reset values: `ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0; state IDLE, `k`=0, `c`=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The partial result is discarded and all outputs return to reset values.

## Timing
- `start` is sampled at edge 0. RUN occupies edges 1..WORDS. `out_valid` rises after edge WORDS, so latency is WORDS+1 cycles from acceptance to `out_valid`.
- The `cpa8` path is combinational within one cycle. Critical path is the 8-bit carry chain plus the slice mux.
- `out_valid` and `out_ready` both high at an edge completes the transfer. `ready` returns to 1 in the next cycle.
- New `start` can be accepted at the earliest one cycle after the transfer. Throughput is one operation per WORDS+2 cycles with `out_ready` tied high.
- `out_ready` low holds DONE indefinitely with outputs stable.
- `out_ready` outside DONE has no effect.

## Configuration
- `CPA8_SEQ_OVF_EN` defined: the `ovf` port exists. During the final slice it is computed as (A_msb XNOR B_msb) AND (sum_msb XOR A_msb), using the stored (possibly inverted) B. It is registered together with `cout` and is valid while `out_valid`=1.
- `CPA8_SEQ_OVF_EN` undefined: there is no `ovf` port and no related logic. All other behaviour is identical.

## Structure
- Shared package `cpa8_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the `SLICE_W`=8 constant.
- A single instance of the existing `cpa8` is the only sub-module. Muxing, inversion and carry register stay in this block.

## Test plan
All scenarios use WORDS=4.
- Carry propagation: a=0x000000FF, b=0x00000001, sub=0 → after 5 cycles `sum`=0x00000100, `cout`=0, `ovf`=0.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, sub=0 → `sum`=0x00000000, `cout`=1, `ovf`=0.
- Subtract with borrow: a=5, b=7, sub=1 → `sum`=0xFFFFFFFE, `cout`=0, `ovf`=0. Also a=7, b=5 → `sum`=2, `cout`=1.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 → `sum`=0x80000000, `ovf`=1 (macro on); no `ovf` port (macro off).
- Handshake: hold `out_ready`=0 for 10 cycles → `out_valid` and `sum` stable, `ready`=0, and `start` pulses ignored. Then raise `out_ready` → `ready`=1 on the next cycle and a back-to-back op completes correctly.
- Reset abort: assert `rst_n`=0 at RUN with `k`=2 → `ready`=1, `out_valid`=0, `sum`=0 immediately. A new op after release yields the correct result.

Source files
------------

// File: rtl/cpa8_seq_pkg.sv
// cpa8_seq_pkg: shared types and constants for the cpa8_seq_add sequencer.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   SLICE_W : width of one adder slice (the shared cpa8 is SLICE_W bits wide)
package cpa8_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cpa8_seq_pkg

// File: rtl/cpa8_seq_add_if.sv
// cpa8_seq_add_if: request/result bundle of the cpa8_seq_add sequencer.
//   Request side : start, sub, a, b (driven by master), ready (driven by slave)
//   Result side  : out_valid, sum, cout [, ovf] (driven by slave), out_ready (master)
//   Parameter    : WORDS = number of 8-bit slices, operand width 8*WORDS
//   Macro        : CPA8_SEQ_OVF_EN adds the signed-overflow flag ovf.
interface cpa8_seq_add_if
  import cpa8_seq_pkg::*;
#(
  parameter int WORDS = 4
);

  localparam int W = SLICE_W * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CPA8_SEQ_OVF_EN
  logic         ovf;
`endif

  // Requesting datapath.
  modport master (
    output start, sub, a, b, out_ready,
    input  ready, out_valid, sum, cout
`ifdef CPA8_SEQ_OVF_EN
    , input ovf
`endif
  );

  // The sequencer itself.
  modport slave (
    input  start, sub, a, b, out_ready,
    output ready, out_valid, sum, cout
`ifdef CPA8_SEQ_OVF_EN
    , output ovf
`endif
  );

endinterface : cpa8_seq_add_if

// File: rtl/cpa8_seq_add_cpa8.sv
// cpa8: 8-bit combinational ripple-carry adder (the shared datapath adder).
//   num1, num2 : addends
//   cin        : carry in
//   out        : num1 + num2 + cin, low SLICE_W bits
//   cout       : carry out of the MSB
module cpa8
  import cpa8_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] num1,
  input  logic [SLICE_W-1:0] num2,
  input  logic               cin,
  output logic [SLICE_W-1:0] out,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
    assign out[gi]     = num1[gi] ^ num2[gi] ^ carry[gi];
    assign carry[gi+1] = (num1[gi] & num2[gi]) | (carry[gi] & (num1[gi] ^ num2[gi]));
  end

  assign cout = carry[SLICE_W];

endmodule : cpa8

// File: rtl/cpa8_seq_add.sv
// cpa8_seq_add: multi-precision add/subtract that reuses one cpa8 over WORDS
// cycles, chaining the carry through a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cpa8_seq_add_if.slave (start/sub/a/b/ready request,
//           out_valid/out_ready/sum/cout[/ovf] result)
//   WORDS : number of 8-bit slices (2..16)
//   Macro : CPA8_SEQ_OVF_EN enables the registered signed-overflow output ovf.
module cpa8_seq_add
  import cpa8_seq_pkg::*;
#(
  parameter int WORDS = 4
)
(
  input  logic         clk,
  input  logic         rst_n,
  cpa8_seq_add_if.slave bus
);

  localparam int W  = SLICE_W * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic          c_q, c_d;
  logic [KW-1:0] k_q, k_d;
  logic          cout_q, cout_d;
`ifdef CPA8_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  // Slice views of the captured operands, selected by k.
  logic [SLICE_W-1:0] a_sl [WORDS];
  logic [SLICE_W-1:0] b_sl [WORDS];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
    assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
    assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
  end

  logic [SLICE_W-1:0] add_a, add_b, add_sum;
  logic               add_cout;

  assign add_a = a_sl[k_q];
  assign add_b = b_sl[k_q];

  cpa8 u_cpa8 (
    .num1 (add_a),
    .num2 (add_b),
    .cin  (c_q),
    .out  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    k_d     = k_q;
    cout_d  = cout_q;
`ifdef CPA8_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          // Subtraction is A + ~B + 1: invert B once here, the +1 enters as cin of slice 0.
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[k_q*SLICE_W +: SLICE_W] = add_sum;
        c_d = add_cout;
        if (k_q == K_LAST) begin
          cout_d  = add_cout;
`ifdef CPA8_SEQ_OVF_EN
          // Operands with equal sign (after B inversion) whose sum flips sign.
          ovf_d   = (add_a[SLICE_W-1] ~^ add_b[SLICE_W-1]) & (add_sum[SLICE_W-1] ^ add_a[SLICE_W-1]);
`endif
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
`ifdef CPA8_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
`ifdef CPA8_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = res_q;
  assign bus.cout      = cout_q;
`ifdef CPA8_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule : cpa8_seq_add
